// File: rtl/otter_dmem_responder.sv
// otter_dmem_responder
//   Responder for the OTTER data-memory port (port 2). Loads and stores are
//   served from a local word RAM, or from an MMIO window at addresses
//   >= IO_BASE. Completion is a one-cycle MEM_READY pulse, optionally with
//   ERR. The response comes after WAIT_STATES extra cycles.
//
// Ports
//   CLK, RST_N            clock and synchronous active-low reset
//   MEM_ADDR2, MEM_DIN2   request byte address and right-justified store data
//   MEM_READ2, MEM_WRITE2 load / store request (held until MEM_READY)
//   MEM_SIZE, MEM_SIGN    0=byte 1=half 2=word 3=illegal; 1=zero-extend
//   MEM_DOUT2             extended load data, valid while MEM_READY=1
//   MEM_READY, ERR        completion pulse and fault flag
//   IO_IN                 MMIO read data
//   IO_ADDR, IO_DOUT      MMIO address (held) and store data
//   IO_WR                 one-cycle MMIO store strobe
module otter_dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic        MEM_READ2,
    input  logic        MEM_WRITE2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT2,
    output logic        MEM_READY,
    output logic        ERR,
    input  logic [31:0] IO_IN,
    output logic [31:0] IO_ADDR,
    output logic [31:0] IO_DOUT,
    output logic        IO_WR
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Request captured on the IDLE accept edge. The fault is decided at
    // accept time, so the later stages only have to gate on one bit.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        uns;
        logic        wr;
        logic        io;
        logic        fault;
    } req_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    req_t        req;
    logic        accept;
    logic        live_fault;

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic [AW-1:0] ram_idx;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ram_we;

    logic        io_ok, io_st;
    logic [31:0] io_addr_q, io_dout_q;
    logic [31:0] src;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    assign accept = (state == IDLE) && (MEM_READ2 || MEM_WRITE2);

    assign live_fault = (MEM_READ2 && MEM_WRITE2)
                     || (MEM_SIZE == 2'd3)
                     || (MEM_SIZE == 2'd1 && MEM_ADDR2[0])
                     || (MEM_SIZE == 2'd2 && MEM_ADDR2[1:0] != 2'b00)
                     || (MEM_ADDR2 < IO_BASE && MEM_ADDR2 >= RAM_BYTES);

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                req.addr  <= MEM_ADDR2;
                req.din   <= MEM_DIN2;
                req.size  <= MEM_SIZE;
                req.uns   <= MEM_SIGN;
                req.wr    <= MEM_WRITE2;
                req.io    <= (MEM_ADDR2 >= IO_BASE);
                req.fault <= live_fault;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_n = WAIT;
                        cnt_n   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_n = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- RAM ----------------
    // Single address port: the live address in IDLE so a zero-wait read is
    // issued on the accept edge, the latched address otherwise. The read
    // runs every cycle, so ram_q is current by RESP. A store commits at the
    // edge that leaves RESP, ahead of any following accept edge.
    assign ram_idx = (state == IDLE) ? MEM_ADDR2[AW+1:2] : req.addr[AW+1:2];
    assign ram_we  = (state == RESP) && req.wr && !req.io && !req.fault;

    always_comb begin
        be    = 4'b1111;
        wdata = req.din;
        case (req.size)
            2'd0: begin
                be    = 4'b0001 << req.addr[1:0];
                wdata = {4{req.din[7:0]}};
            end
            2'd1: begin
                be    = req.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req.din[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        ram_q <= ram[ram_idx];
    end

    // ---------------- load extraction ----------------
    assign src    = req.io ? IO_IN : ram_q;
    assign lane_b = src[{req.addr[1:0], 3'b000} +: 8];
    assign lane_h = req.addr[1] ? src[31:16] : src[15:0];

    always_comb begin
        case (req.size)
            2'd0:    ld_data = req.uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    ld_data = req.uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_data = src;
        endcase
    end

    // ---------------- MMIO ----------------
    assign io_ok = (state == RESP) && req.io && !req.fault;
    assign io_st = io_ok && req.wr;

    // The held copies update as RESP ends. During RESP the outputs bypass
    // straight from the latched request.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            io_addr_q <= '0;
            io_dout_q <= '0;
        end else begin
            if (io_ok) io_addr_q <= req.addr;
            if (io_st) io_dout_q <= req.din;
        end
    end

    assign IO_ADDR   = io_ok ? req.addr : io_addr_q;
    assign IO_DOUT   = io_st ? req.din  : io_dout_q;
    assign IO_WR     = io_st;

    assign MEM_READY = (state == RESP);
    assign ERR       = (state == RESP) && req.fault;
    assign MEM_DOUT2 = ((state == RESP) && !req.wr && !req.fault) ? ld_data : 32'd0;

endmodule

// File: tb/tb_otter_dmem_responder.sv
module tb_otter_dmem_responder;
    localparam int WS    = 1;
    localparam int DEPTH = 4096;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] MEM_ADDR2 = '0, MEM_DIN2 = '0, IO_IN = '0;
    logic        MEM_READ2 = 1'b0, MEM_WRITE2 = 1'b0, MEM_SIGN = 1'b0;
    logic [1:0]  MEM_SIZE = 2'd2;
    logic [31:0] MEM_DOUT2, IO_ADDR, IO_DOUT;
    logic        MEM_READY, ERR, IO_WR;

    otter_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .IO_BASE(32'h1100_0000)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2), .MEM_READY(MEM_READY), .ERR(ERR),
        .IO_IN(IO_IN), .IO_ADDR(IO_ADDR), .IO_DOUT(IO_DOUT), .IO_WR(IO_WR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] dout; logic err; int issue; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } io_t;
    exp_t sbq[$];
    io_t  ioq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every completion pops one expectation, every IO strobe pops one.
    initial begin
        exp_t e;
        io_t  w;
        forever begin
            @(negedge CLK);
            if (MEM_READY) begin
                if (sbq.size() == 0) chk("unexpected_ready", 32'(MEM_READY), 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("dout",    MEM_DOUT2,           e.dout);
                    chk("err",     32'(ERR),            32'(e.err));
                    chk("latency", 32'(cyc - e.issue),  32'(1 + WS));
                end
            end
            if (IO_WR) begin
                if (ioq.size() == 0) chk("unexpected_io_wr", 32'(IO_WR), 32'd0);
                else begin
                    w = ioq.pop_front();
                    chk("io_addr", IO_ADDR, w.addr);
                    chk("io_dout", IO_DOUT, w.data);
                end
            end
        end
    end

    task automatic wait_ready;
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!MEM_READY && n < 50);
        if (!MEM_READY) chk("ready_timeout", 32'(MEM_READY), 32'd1);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic uns);
        MEM_READ2 = rd; MEM_WRITE2 = wr; MEM_ADDR2 = a; MEM_DIN2 = d;
        MEM_SIZE = sz; MEM_SIGN = uns;
    endtask

    // One request, held until MEM_READY and dropped during the READY cycle.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns, input logic [31:0] edout, input logic eerr);
        @(negedge CLK);
        drive(rd, wr, a, d, sz, uns);
        sbq.push_back('{edout, eerr, cyc});
        wait_ready();
        MEM_READ2 = 1'b0; MEM_WRITE2 = 1'b0;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic eerr);
        req(1'b0, 1'b1, a, d, sz, 1'b0, 32'd0, eerr);
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] edout, input logic eerr);
        req(1'b1, 1'b0, a, 32'd0, sz, uns, edout, eerr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ready",   32'(MEM_READY), 32'd0);
        chk("rst_err",     32'(ERR),       32'd0);
        chk("rst_dout",    MEM_DOUT2,      32'd0);
        chk("rst_io_wr",   32'(IO_WR),     32'd0);
        chk("rst_io_addr", IO_ADDR,        32'd0);
        chk("rst_io_dout", IO_DOUT,        32'd0);
        RST_N = 1'b1;

        // word store / load
        st(2'd2, 32'h100, 32'hDEAD_BEEF, 1'b0);
        ld(2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0);
        // byte store touches one lane only, upper DIN bits ignored
        st(2'd0, 32'h103, 32'hAAAA_AA80, 1'b0);
        ld(2'd0, 1'b0, 32'h103, 32'hFFFF_FF80, 1'b0);
        ld(2'd0, 1'b1, 32'h103, 32'h0000_0080, 1'b0);
        ld(2'd2, 1'b0, 32'h100, 32'h80AD_BEEF, 1'b0);
        // half loads
        ld(2'd1, 1'b0, 32'h102, 32'hFFFF_80AD, 1'b0);
        ld(2'd1, 1'b1, 32'h100, 32'h0000_BEEF, 1'b0);
        ld(2'd1, 1'b0, 32'h100, 32'hFFFF_BEEF, 1'b0);
        // misaligned half store faults, word unchanged
        st(2'd1, 32'h101, 32'h0000_1111, 1'b1);
        ld(2'd2, 1'b0, 32'h100, 32'h80AD_BEEF, 1'b0);
        // half store to upper lanes
        st(2'd1, 32'h102, 32'hFFFF_1234, 1'b0);
        ld(2'd2, 1'b0, 32'h100, 32'h1234_BEEF, 1'b0);
        ld(2'd0, 1'b0, 32'h101, 32'hFFFF_FFBE, 1'b0);
        ld(2'd0, 1'b1, 32'h100, 32'h0000_00EF, 1'b0);

        // MMIO
        ioq.push_back('{32'h1100_0004, 32'h0000_0055});
        st(2'd2, 32'h1100_0004, 32'h0000_0055, 1'b0);
        IO_IN = 32'h0000_1234;
        ld(2'd2, 1'b0, 32'h1100_0000, 32'h0000_1234, 1'b0);
        ld(2'd0, 1'b1, 32'h1100_0001, 32'h0000_0012, 1'b0);
        IO_IN = 32'h8765_1234;
        ld(2'd1, 1'b0, 32'h1100_0002, 32'hFFFF_8765, 1'b0);
        @(negedge CLK);
        chk("io_addr_hold", IO_ADDR, 32'h1100_0002);
        chk("io_dout_hold", IO_DOUT, 32'h0000_0055);

        // faults: no RAM write, no IO strobe, DOUT2 = 0
        req(1'b1, 1'b1, 32'h100,       32'h0,         2'd2, 1'b0, 32'd0, 1'b1);
        req(1'b1, 1'b1, 32'h1100_0004, 32'h77,        2'd2, 1'b0, 32'd0, 1'b1);
        st(2'd2, 32'h4000, 32'hCAFE_F00D, 1'b1);
        ld(2'd2, 1'b0, 32'h4000, 32'd0, 1'b1);
        ld(2'd3, 1'b0, 32'h100,  32'd0, 1'b1);
        ld(2'd2, 1'b0, 32'h102,  32'd0, 1'b1);
        st(2'd2, 32'h10FF_FFFC, 32'h1, 1'b1);
        ld(2'd2, 1'b0, 32'h100, 32'h1234_BEEF, 1'b0);
        // last RAM word
        st(2'd2, 32'h3FFC, 32'hA5A5_5A5A, 1'b0);
        ld(2'd2, 1'b0, 32'h3FFC, 32'hA5A5_5A5A, 1'b0);
        @(negedge CLK);
        chk("io_addr_after_faults", IO_ADDR, 32'h1100_0002);

        // reset while a store sits in WAIT
        @(negedge CLK);
        drive(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 2'd2, 1'b0);
        @(negedge CLK);
        chk("wait_no_ready", 32'(MEM_READY), 32'd0);
        RST_N = 1'b0; MEM_WRITE2 = 1'b0;
        @(negedge CLK);
        chk("rst_mid_ready",   32'(MEM_READY), 32'd0);
        chk("rst_mid_io_addr", IO_ADDR,        32'd0);
        chk("rst_mid_io_dout", IO_DOUT,        32'd0);
        RST_N = 1'b1;
        ld(2'd2, 1'b0, 32'h100, 32'h1234_BEEF, 1'b0);

        // request held through READY is taken again on the next IDLE cycle
        @(negedge CLK);
        drive(1'b1, 1'b0, 32'h3FFC, 32'h0, 2'd2, 1'b0);
        sbq.push_back('{32'hA5A5_5A5A, 1'b0, cyc});
        sbq.push_back('{32'hA5A5_5A5A, 1'b0, cyc + 2 + WS});
        wait_ready();
        wait_ready();
        MEM_READ2 = 1'b0;

        repeat (6) @(negedge CLK);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("io_empty", 32'(ioq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
